iter_sched_ctrl: RTL and testbench

Parametrised successor of the fixed-count iteration controller for the level-crossing reconstruction loop. It runs an FSM with runtime-configurable iteration count and block length. It loads one block of level-generator samples into the signal and limits buffers, then runs N FIR/hard-limiter passes over that block. It sits between lvl_gen, sigbuff, limbuff, fir_fe, limiter and out_ctrl, and aligns the write-back and output windows to the FIR latency through an internal delay line.

---
 rtl/iter_sched_pkg.sv | 14 +
 rtl/iter_sched_dly_line.sv | 25 ++
 rtl/iter_sched_ctrl.sv | 157 +++++++++++++++
 tb/tb_iter_sched_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/iter_sched_pkg.sv
// Shared types and helpers for the iteration scheduler: FSM states, default widths, config clamping.
package iter_sched_pkg;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_ITER_W = 5;

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

  // Zero is promoted to one; anything above hi saturates at hi.
  function automatic int unsigned clamp1(input int unsigned v, input int unsigned hi);
    if (v == 0) return 1;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/iter_sched_dly_line.sv
// Single-bit shift register of DEPTH stages with synchronous active-low clear.
module iter_sched_dly_line #(
  parameter int DEPTH = 16
) (
  input  logic clock,
  input  logic clear_n,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clock) begin
      if (!clear_n) sr <= '0;
      else          sr <= din;
    end
  end else begin : g_many
    always_ff @(posedge clock) begin
      if (!clear_n) sr <= '0;
      else          sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/iter_sched_ctrl.sv
// Block load + N-pass FIR/limiter iteration controller with FIR-latency-aligned write-back window.
// Optional ITER_CTRL_ABORT_EN adds an abort input and a one-cycle aborted pulse.
module iter_sched_ctrl
  import iter_sched_pkg::*;
#(
  parameter int MAX_SAMPLES_IN_RAM = 255,
  parameter int MAX_ITER_NUM       = 31,
  parameter int CNT_W              = DEF_CNT_W,
  parameter int ITER_W             = DEF_ITER_W,
  parameter int FIR_LATENCY        = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ITER_W-1:0] cfg_iter_num,
  input  logic [CNT_W-1:0]  cfg_block_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              lvl_gen_valid,
  output logic              lvl_gen_ready,
  output logic [ITER_W-1:0] sigbuff_iter_num,
  output logic              sigbuff_input_mux,
  output logic              sigbuff_input_enable,
  output logic              sigbuff_output_enable,
  output logic              limbuff_input_enable,
  output logic              limbuff_output_enable,
  output logic              fir_input_enable,
  output logic              limiter_input_enable,
  output logic              out_ctrl_output_enable
`ifdef ITER_CTRL_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);
  localparam int DW = (FIR_LATENCY > 1) ? $clog2(FIR_LATENCY) : 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  sym_cnt, sym_cnt_nx, len_q, len_nx;
  logic [ITER_W-1:0] iter, iter_nx, iter_n_q, iter_n_nx;
  logic [DW-1:0]     drain_cnt, drain_cnt_nx;
  logic              acc, last_iter, in_loop, dly, abort_fire;

`ifdef ITER_CTRL_ABORT_EN
  assign abort_fire = abort && (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) aborted <= 1'b0;
    else          aborted <= abort_fire;
  end
`else
  assign abort_fire = 1'b0;
`endif

  assign in_loop       = (state == FEED) || (state == DRAIN);
  assign last_iter     = (iter == iter_n_q - ITER_W'(1));
  assign lvl_gen_ready = (state == LOAD) && (sym_cnt < len_q);
  assign acc           = lvl_gen_valid && lvl_gen_ready;

  always_comb begin
    state_nx     = state;
    sym_cnt_nx   = sym_cnt;
    iter_nx      = iter;
    drain_cnt_nx = drain_cnt;
    len_nx       = len_q;
    iter_n_nx    = iter_n_q;
    case (state)
      IDLE: if (start) begin
        len_nx     = CNT_W'(clamp1(32'(cfg_block_len), MAX_SAMPLES_IN_RAM));
        iter_n_nx  = ITER_W'(clamp1(32'(cfg_iter_num), MAX_ITER_NUM));
        sym_cnt_nx = '0;
        iter_nx    = '0;
        state_nx   = LOAD;
      end
      LOAD: if (acc) begin
        if (sym_cnt == len_q - CNT_W'(1)) begin
          sym_cnt_nx = '0;
          iter_nx    = '0;
          state_nx   = FEED;
        end else begin
          sym_cnt_nx = sym_cnt + CNT_W'(1);
        end
      end
      FEED: begin
        if (sym_cnt == len_q - CNT_W'(1)) begin
          sym_cnt_nx   = '0;
          drain_cnt_nx = '0;
          state_nx     = DRAIN;
        end else begin
          sym_cnt_nx = sym_cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(FIR_LATENCY - 1)) begin
          drain_cnt_nx = '0;
          if (last_iter) begin
            state_nx = DONE;
          end else begin
            iter_nx  = iter + ITER_W'(1);
            state_nx = FEED;
          end
        end else begin
          drain_cnt_nx = drain_cnt + DW'(1);
        end
      end
      DONE: begin
        iter_nx  = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_fire) begin
      state_nx     = IDLE;
      sym_cnt_nx   = '0;
      iter_nx      = '0;
      drain_cnt_nx = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      sym_cnt   <= '0;
      iter      <= '0;
      drain_cnt <= '0;
      len_q     <= '0;
      iter_n_q  <= '0;
    end else begin
      state     <= state_nx;
      sym_cnt   <= sym_cnt_nx;
      iter      <= iter_nx;
      drain_cnt <= drain_cnt_nx;
      len_q     <= len_nx;
      iter_n_q  <= iter_n_nx;
    end
  end

  // Emptying the delay line on abort keeps stale FIR strobes from leaking into a later run.
  iter_sched_dly_line #(.DEPTH(FIR_LATENCY)) u_dly (
    .clock   (clock),
    .clear_n (reset_n && !abort_fire),
    .din     (fir_input_enable),
    .dout    (dly)
  );

  assign busy                   = (state != IDLE);
  assign done                   = (state == DONE);
  assign sigbuff_iter_num       = iter;
  assign sigbuff_input_mux      = in_loop;
  assign fir_input_enable       = (state == FEED);
  assign sigbuff_output_enable  = (state == FEED);
  assign limbuff_output_enable  = (state == FEED);
  assign limbuff_input_enable   = acc;
  assign limiter_input_enable   = dly && in_loop;
  assign sigbuff_input_enable   = acc || (dly && in_loop && !last_iter);
  assign out_ctrl_output_enable = dly && in_loop && last_iter;
endmodule

// File: tb/tb_iter_sched_ctrl.sv
// Randomised/directed bench for iter_sched_ctrl against an arithmetic timeline model.
module tb_iter_sched_ctrl;
  localparam int MAXS = 255, MAXI = 31, CW = 8, IW = 5, FL = 3;

  logic          clock = 1'b0;
  logic          reset_n, start, lvl_gen_valid, abort_w;
  logic [IW-1:0] cfg_iter_num;
  logic [CW-1:0] cfg_block_len;
  logic          busy, done, lvl_gen_ready, sigbuff_input_mux, sigbuff_input_enable;
  logic          sigbuff_output_enable, limbuff_input_enable, limbuff_output_enable;
  logic          fir_input_enable, limiter_input_enable, out_ctrl_output_enable, aborted_w;
  logic [IW-1:0] sigbuff_iter_num;

  logic v [0:2047];
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  iter_sched_ctrl #(
    .MAX_SAMPLES_IN_RAM(MAXS), .MAX_ITER_NUM(MAXI), .CNT_W(CW), .ITER_W(IW), .FIR_LATENCY(FL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cfg_iter_num(cfg_iter_num), .cfg_block_len(cfg_block_len),
    .start(start), .busy(busy), .done(done), .lvl_gen_valid(lvl_gen_valid),
    .lvl_gen_ready(lvl_gen_ready), .sigbuff_iter_num(sigbuff_iter_num),
    .sigbuff_input_mux(sigbuff_input_mux), .sigbuff_input_enable(sigbuff_input_enable),
    .sigbuff_output_enable(sigbuff_output_enable), .limbuff_input_enable(limbuff_input_enable),
    .limbuff_output_enable(limbuff_output_enable), .fir_input_enable(fir_input_enable),
    .limiter_input_enable(limiter_input_enable), .out_ctrl_output_enable(out_ctrl_output_enable)
`ifdef ITER_CTRL_ABORT_EN
    , .abort(abort_w), .aborted(aborted_w)
`endif
  );
`ifndef ITER_CTRL_ABORT_EN
  assign aborted_w = 1'b0;
`endif

  // Expected outputs at cycle k after start; the run is LOAD for L cycles, then itn periods of
  // (ln feed + FL drain), then one DONE cycle. Result strobes lag feed strobes by FL.
  function automatic logic [16:0] model(input int k, input int L, input int itn, input int ln);
    logic bsy, dn, rdy, sbi, mux, sbo, lbi, lbo, fir, lim, oc;
    logic [IW-1:0] itv;
    int p, j, it, fend;
    bsy = 0; dn = 0; rdy = 0; sbi = 0; mux = 0; sbo = 0; lbi = 0; lbo = 0;
    fir = 0; lim = 0; oc = 0; itv = '0;
    p = ln + FL;
    fend = L + itn * p;
    if (k < L) begin
      bsy = 1; rdy = 1; sbi = v[k]; lbi = v[k];
    end else if (k < fend) begin
      j = k - L; it = j / p;
      bsy = 1; mux = 1; itv = IW'(it);
      if (j % p < ln) begin fir = 1; sbo = 1; lbo = 1; end
      if ((j % p >= FL) && (j % p - FL < ln)) begin
        lim = 1;
        if (it == itn - 1) oc = 1; else sbi = 1;
      end
    end else if (k == fend) begin
      bsy = 1; dn = 1; itv = IW'(itn - 1);
    end
    return {bsy, dn, rdy, sbi, mux, sbo, lbi, lbo, fir, lim, oc, 1'b0, itv};
  endfunction

  task automatic check(input string tag, input int k, input logic [16:0] expv);
    logic [16:0] obs;
    obs = {busy, done, lvl_gen_ready, sigbuff_input_enable, sigbuff_input_mux,
           sigbuff_output_enable, limbuff_input_enable, limbuff_output_enable,
           fir_input_enable, limiter_input_enable, out_ctrl_output_enable, aborted_w,
           sigbuff_iter_num};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  // vmode: 0 valid held, 1 valid on odd cycles, 2 random. rst_off is relative to iteration-1
  // FEED start, abt_off relative to FEED start; -1 disables either.
  task automatic run(input int cfg_it, input int cfg_ln, input int vmode,
                     input int rst_off, input int abt_off, input string tag);
    int itn, ln, L, n, fend, cut, last;
    itn = (cfg_it == 0) ? 1 : ((cfg_it > MAXI) ? MAXI : cfg_it);
    ln  = (cfg_ln == 0) ? 1 : ((cfg_ln > MAXS) ? MAXS : cfg_ln);
    for (int k = 0; k < 2048; k++)
      v[k] = (vmode == 0) ? 1'b1 : (vmode == 1) ? (k % 2 == 1) : ($urandom_range(0, 3) != 0);
    n = 0; L = 0;
    for (int k = 0; k < 2048 && n < ln; k++) begin
      if (v[k]) n++;
      L = k + 1;
    end
    fend = L + itn * (ln + FL);
    cut  = (rst_off >= 0) ? L + (ln + FL) + rst_off : (abt_off >= 0) ? L + abt_off : -1;
    last = (cut >= 0) ? cut + 2 : fend + 2;

    start = 1'b1; lvl_gen_valid = 1'b1;
    cfg_iter_num = IW'(cfg_it); cfg_block_len = CW'(cfg_ln);
    @(negedge clock);
    check({tag, "_start"}, -1, 17'h0);
    @(posedge clock); #1;
    start = 1'b0;
    cfg_iter_num = IW'($urandom); cfg_block_len = CW'($urandom);
    for (int k = 0; k <= last; k++) begin
      lvl_gen_valid = v[k];
      start   = (k == L);
      reset_n = !(rst_off >= 0 && k == cut);
      abort_w = (abt_off >= 0 && k == cut);
      @(negedge clock);
      if (cut >= 0 && k > cut)
        check(tag, k, (abt_off >= 0 && k == cut + 1) ? 17'h00020 : 17'h0);
      else
        check(tag, k, model(k, L, itn, ln));
      @(posedge clock); #1;
    end
    start = 1'b0; abort_w = 1'b0; reset_n = 1'b1; lvl_gen_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; lvl_gen_valid = 1'b1; abort_w = 1'b0;
    cfg_iter_num = '0; cfg_block_len = '0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("reset", 0, 17'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_after_reset", 0, 17'h0);
    @(posedge clock); #1;

    run(1, 4, 0, -1, -1, "it1_len4");
    run(3, 8, 1, -1, -1, "it3_len8_toggle");
    run(0, 0, 0, -1, -1, "zero_cfg");
    run(1, 255, 0, -1, -1, "len_max");
    run(2, 6, 0, 2, -1, "reset_mid_feed");
    run(2, 5, 2, -1, -1, "after_reset");
    for (int i = 0; i < 6; i++)
      run($urandom_range(0, 4), $urandom_range(0, 12), $urandom_range(0, 2), -1, -1, "random");
`ifdef ITER_CTRL_ABORT_EN
    run(2, 4, 0, -1, 4 + 1, "abort_drain");
    run(1, 3, 0, -1, -1, "after_abort");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
